// File: rtl/bit_reversal_reader_pkg.sv
// Shared constants for the bit-reversal reader: FSM encodings, size limits and index width.
// The optional protocol checker is enabled with the BR_READER_CHECK_EN macro.
package bit_reversal_reader_pkg;

  localparam int unsigned MAX_POINT = 1024;
  localparam int unsigned IDX_W     = 10;
  localparam int unsigned PNT_W     = 11;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  // True for powers of two in 2..MAX_POINT.
  function automatic logic is_pow2_point(input logic [PNT_W-1:0] p);
    return (p >= PNT_W'(2)) && (p <= PNT_W'(MAX_POINT)) &&
           ((p & (p - PNT_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/bit_reversal_reader_br_point_check.sv
// Combinational FFT-size helper: legality of the incoming size, its power-of-two
// normalisation, and the terminal bin index of the latched size.
module br_point_check
  import bit_reversal_reader_pkg::*;
(
  input  logic [PNT_W-1:0] point_i,
  input  logic [PNT_W-1:0] r_point_i,
  output logic             legal_o,
  output logic [PNT_W-1:0] norm_point_o,
  output logic [IDX_W-1:0] term_o
);

  assign legal_o = is_pow2_point(point_i);

  // Highest set bit wins; sizes below 2 are treated as 2.
  always_comb begin
    norm_point_o = PNT_W'(2);
    for (int b = 1; b < PNT_W; b++) begin
      if (point_i[b]) begin
        norm_point_o = PNT_W'(1) << b;
      end
    end
  end

  always_comb begin
    if (r_point_i[PNT_W-1]) begin
      term_o = '1;
    end else begin
      term_o = r_point_i[IDX_W-1:0] - IDX_W'(1);
    end
  end

endmodule

// File: rtl/bit_reversal_reader.sv
// Streams bank read data out in natural order, tagging frame start/end, bin index and
// frame count. Define BR_READER_CHECK_EN to enable gap/bank/size error detection and o_err.
module bit_reversal_reader
  import bit_reversal_reader_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       i_point,
  input  logic              i_valid,
  input  logic              i_bank_sel,
  input  logic [DWIDTH-1:0] i_rdata0,
  input  logic [DWIDTH-1:0] i_rdata1,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  output logic              o_sof,
  output logic              o_eof,
  output logic [9:0]        o_index,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_err
);

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PNT_W-1:0]  point_q, point_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] data_q;
  logic              valid_q, sof_q, eof_q;
  logic [IDX_W-1:0]  index_q;

  logic              start, emit, sof, eof, err;
  logic [IDX_W-1:0]  index;
  logic              start_ok, stream_fault;
  logic              legal;
  logic [PNT_W-1:0]  norm_point;
  logic [IDX_W-1:0]  term;

  br_point_check u_point_check (
    .point_i      (i_point),
    .r_point_i    (point_q),
    .legal_o      (legal),
    .norm_point_o (norm_point),
    .term_o       (term)
  );

`ifdef BR_READER_CHECK_EN
  logic bank_q;
  logic err_q;

  assign start_ok     = legal;
  assign stream_fault = !i_valid || (i_bank_sel != bank_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (start) begin
        bank_q <= i_bank_sel;
      end
      err_q <= err;
    end
  end

  assign o_err = err_q;
`else
  logic unused_legal;
  logic unused_err;

  assign unused_legal = legal;
  assign unused_err   = err;
  assign start_ok     = 1'b1;
  assign stream_fault = 1'b0;
  assign o_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    point_d = point_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    emit    = 1'b0;
    sof     = 1'b0;
    eof     = 1'b0;
    err     = 1'b0;
    index   = '0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (start_ok) begin
            start   = 1'b1;
            emit    = 1'b1;
            sof     = 1'b1;
            point_d = norm_point;
            idx_d   = IDX_W'(1);
            state_d = S_STREAM;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (stream_fault) begin
          // Drop the partial frame; the offending sample is not emitted.
          err     = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (i_valid) begin
          emit  = 1'b1;
          index = idx_q;
          if (idx_q == term) begin
            eof     = 1'b1;
            cnt_d   = cnt_q + FCNT_W'(1);
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      point_q <= PNT_W'(2);
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      point_q <= point_d;
      cnt_q   <= cnt_d;
      valid_q <= emit;
      sof_q   <= sof;
      eof_q   <= eof;
      index_q <= index;
      if (emit) begin
        data_q <= i_bank_sel ? i_rdata1 : i_rdata0;
      end
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_index     = index_q;
  assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_bit_reversal_reader.sv
// Scoreboard bench for bit_reversal_reader: a frame-level reference model pushes the
// expected output of every driven cycle; a monitor pops and compares on the next negedge.
module tb_bit_reversal_reader;

  localparam int DW = 32;
  localparam int FW = 8;
`ifdef BR_READER_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   i_point;
  logic          i_valid;
  logic          i_bank_sel;
  logic [DW-1:0] i_rdata0, i_rdata1;
  logic [DW-1:0] o_data;
  logic          o_valid, o_sof, o_eof, o_err;
  logic [9:0]    o_index;
  logic [FW-1:0] o_frame_cnt;

  always #5 clk = ~clk;

  bit_reversal_reader #(
    .DWIDTH (DW),
    .FCNT_W (FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_point     (i_point),
    .i_valid     (i_valid),
    .i_bank_sel  (i_bank_sel),
    .i_rdata0    (i_rdata0),
    .i_rdata1    (i_rdata1),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_index     (o_index),
    .o_frame_cnt (o_frame_cnt),
    .o_err       (o_err)
  );

  typedef struct packed {
    logic          valid;
    logic          sof;
    logic          eof;
    logic [9:0]    index;
    logic [DW-1:0] data;
    logic [FW-1:0] cnt;
    logic          err;
  } obs_t;

  obs_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: frame-level view of the stream.
  bit          m_busy;
  int          m_pos, m_npoint, m_frames;
  bit          m_bank;
  logic [DW-1:0] m_last;

  function automatic bit legal_pt(int p);
    for (int k = 1; k <= 10; k++) if (p == (1 << k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int floor_pt(int p);
    int r = 2;
    for (int k = 1; k <= 10; k++) if (p >= (1 << k)) r = 1 << k;
    return r;
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_pos = 0; m_npoint = 2; m_frames = 0; m_bank = 0; m_last = '0;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step(bit v, bit bank, int point, logic [DW-1:0] d0, logic [DW-1:0] d1);
    obs_t e;
    bit   emit = 1'b0;
    @(negedge clk);
    i_valid = v; i_bank_sel = bank; i_point = 11'(point); i_rdata0 = d0; i_rdata1 = d1;
    e = '0;
    if (!m_busy) begin
      if (v) begin
        if (CHECK && !legal_pt(point)) e.err = 1'b1;
        else begin
          m_busy = 1; m_npoint = floor_pt(point); m_bank = bank; m_pos = 1;
          emit = 1'b1; e.sof = 1'b1;
        end
      end
    end else if (CHECK && (!v || bank != m_bank)) begin
      e.err = 1'b1; m_busy = 0;
    end else if (v) begin
      emit = 1'b1; e.index = 10'(m_pos);
      if (m_pos == m_npoint - 1) begin
        e.eof = 1'b1; m_frames++; m_busy = 0;
      end else m_pos++;
    end
    if (emit) begin
      e.valid = 1'b1;
      m_last = bank ? d1 : d0;
    end
    e.data = m_last;
    e.cnt  = FW'(m_frames);
    @(posedge clk);
    #1 q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1; i_valid = 1'b0; i_bank_sel = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_flags", {61'd0, o_sof, o_eof, o_err}, 64'd0);
    chk("rst_index", 64'(o_index), 64'd0);
    chk("rst_cnt", 64'(o_frame_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor
  initial begin
    forever begin
      obs_t e, g;
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        g = {o_valid, o_sof, o_eof, o_index, o_data, o_frame_cnt, o_err};
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL scoreboard t=%0t got v=%0b sof=%0b eof=%0b idx=%0d data=%h cnt=%0d err=%0b exp v=%0b sof=%0b eof=%0b idx=%0d data=%h cnt=%0d err=%0b",
                   $time, g.valid, g.sof, g.eof, g.index, g.data, g.cnt, g.err,
                   e.valid, e.sof, e.eof, e.index, e.data, e.cnt, e.err);
        end
      end
    end
  end

  initial begin
    int pts[7] = '{2, 4, 8, 16, 32, 64, 12};
    int pt;
    bit bk;
    reset = 1'b1; i_valid = 0; i_bank_sel = 0; i_point = 11'd8;
    i_rdata0 = '0; i_rdata1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    do_reset();

    // Single 8-point frame, data 0..7.
    for (int i = 0; i < 8; i++) step(1, 0, 8, DW'(i), $urandom);
    // Two back-to-back 16-point frames, bank 0 then bank 1.
    for (int i = 0; i < 32; i++) step(1, i >= 16, 16, $urandom, $urandom);
    // Gap after 5 samples, then a full frame.
    for (int i = 0; i < 5; i++) step(1, 0, 16, $urandom, $urandom);
    step(0, 0, 16, $urandom, $urandom);
    for (int i = 0; i < 16; i++) step(1, 0, 16, $urandom, $urandom);
    // Illegal size.
    step(1, 0, 12, $urandom, $urandom);
    step(0, 0, 12, $urandom, $urandom);
    do_reset();
    // Bank toggles at sample 3 of a 64-point frame.
    for (int i = 0; i < 64; i++) step(1, i >= 3, 64, $urandom, $urandom);
    do_reset();
    // Reset at sample 10 of a 1024-point frame, then a clean 1024-point frame.
    for (int i = 0; i < 10; i++) step(1, 0, 1024, $urandom, $urandom);
    do_reset();
    for (int i = 0; i < 1024; i++) step(1, 1, 1024, $urandom, $urandom);

    // Randomised traffic with occasional gaps, bank flips and mid-frame size changes.
    pt = 8; bk = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) pt = pts[$urandom_range(0, 6)];
      if ($urandom_range(0, 29) == 0) bk = ~bk;
      step($urandom_range(0, 19) != 0, bk, pt, $urandom, $urandom);
    end

    // Frame counter wrap: 2^FW two-point frames from reset.
    do_reset();
    for (int i = 0; i < (1 << FW); i++) begin
      step(1, i[0], 2, $urandom, $urandom);
      step(1, i[0], 2, $urandom, $urandom);
    end
    @(negedge clk);
    #1;
    chk("cnt_wrap", 64'(o_frame_cnt), 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_reversal_reader.md
BIT_REVERSAL_READER -- requirements
Module: bit_reversal_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, giving the data width of the bank read data and the output sample.
REQ-002 SHALL have parameter FCNT_W, default 16, giving the width of the frame counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_point, input, 11 bits: FFT size; legal values are 2,4,...,1024.
REQ-006 SHALL have port i_valid, input, 1 bit: qualifies bank read data from the bit-reversal writer.
REQ-007 SHALL have port i_bank_sel, input, 1 bit: selects the bank being read (0 selects bank 0, 1 selects bank 1).
REQ-008 SHALL have port i_rdata0, input, DWIDTH bits: bank 0 read data, aligned with i_valid.
REQ-009 SHALL have port i_rdata1, input, DWIDTH bits: bank 1 read data, aligned with i_valid.
REQ-010 SHALL have port o_data, output, DWIDTH bits: natural-order output sample.
REQ-011 SHALL have port o_valid, output, 1 bit: qualifies o_data.
REQ-012 SHALL have port o_sof, output, 1 bit: asserted with the first sample of a frame (bin 0).
REQ-013 SHALL have port o_eof, output, 1 bit: asserted with the last sample of a frame (bin i_point-1).
REQ-014 SHALL have port o_index, output, 10 bits: bin index of o_data.
REQ-015 SHALL have port o_frame_cnt, output, FCNT_W bits: count of completed frames.
REQ-016 SHALL have port o_err, output, 1 bit: one-cycle pulse on a protocol error.

Function
REQ-017 SHALL register outputs with 1-cycle latency: o_data <= i_bank_sel ? i_rdata1 : i_rdata0 and o_valid <= i_valid, except where REQ-022 and REQ-023 force o_valid low.
REQ-018 SHALL implement the states S_IDLE and S_STREAM; the counter r_idx and the latched size r_point are held in the block.
REQ-019 S_IDLE: on i_valid with a legal i_point, SHALL latch r_point = i_point and r_bank = i_bank_sel, emit the sample with o_sof=1 and o_index=0, set r_idx=1, and go to S_STREAM; if r_point==2 the second sample ends the frame.
REQ-020 S_STREAM: on each i_valid SHALL emit the sample with o_index=r_idx and increment r_idx; when r_idx==r_point-1, SHALL assert o_eof, increment o_frame_cnt (wrapping at 2^FCNT_W), clear r_idx, and go to S_IDLE.
REQ-021 For a back-to-back frame (i_valid high in the cycle after eof, bank toggled), SHALL accept it through S_IDLE with no bubble.
REQ-022 If i_valid is low in S_STREAM (gap mid-frame), or i_bank_sel differs from r_bank: SHALL pulse o_err, drop the frame without asserting o_eof, leave o_frame_cnt unchanged, clear r_idx, go to S_IDLE, and suppress o_valid for the offending sample.
REQ-023 Illegal i_point (not a power of two in 2..1024) sampled in S_IDLE with i_valid: SHALL pulse o_err, keep o_valid=0, and stay in S_IDLE.
REQ-024 A change of i_point mid-frame SHALL be ignored; r_point governs until eof.
REQ-025 When o_valid=0, o_sof, o_eof and o_index SHALL be 0 and o_data SHALL hold its last value.

Reset
REQ-026 While reset is asserted: state S_IDLE, r_idx=0, o_data=0, o_valid=0, o_sof=0, o_eof=0, o_index=0, o_frame_cnt=0, o_err=0; reset mid-frame discards the partial frame.

Configuration
REQ-027 With BR_READER_CHECK_EN defined, SHALL implement the error detection of REQ-022 and REQ-023 and the o_err output.
REQ-028 Without BR_READER_CHECK_EN, SHALL tie o_err to 0, skip the bank-mismatch and gap checks, and treat any i_point as a power of two via r_point.

Structure
REQ-029 The shared package SHALL hold the state encodings, MAX_POINT=1024, and the index width 10.
REQ-030 A sub-module br_point_check SHALL provide the combinational legality check of i_point and the derived r_point-1 terminal value.

Verification
REQ-031 i_point=8, 8 consecutive valids from bank 0 carrying data 0..7 -> o_data 0..7 one cycle later, o_sof on bin 0, o_eof on bin 7, o_frame_cnt=1.
REQ-032 i_point=16, two back-to-back frames with bank 0 then bank 1 -> 32 contiguous o_valid cycles, o_frame_cnt=2, o_err never asserted.
REQ-033 i_point=16, i_valid dropped after 5 samples -> o_err pulses once, no o_eof, o_frame_cnt=0; the next full frame starts at o_index=0.
REQ-034 i_point=12 with i_valid high -> o_err=1 and o_valid=0 (CHECK_EN defined).
REQ-035 i_bank_sel toggled at sample 3 of a 64-point frame -> o_err pulses and the frame is dropped; reset asserted at sample 10 of a 1024-point frame -> all outputs 0 and the next frame is correct.
REQ-036 o_frame_cnt preloaded near 2^16-1 by running 65536 2-point frames -> o_frame_cnt wraps to 0.
